// File: rtl/triplet_packer.sv
// Groups a serial ready/valid sample stream into a/b/c triplets for the averager, and tracks avg validity.
// Optional PARTIAL_FLUSH_EN: flush pads and closes a partial triplet; otherwise flush is ignored.
module triplet_packer #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              avg_valid,
  output logic [CNT_W-1:0]  trip_cnt
);

  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  state_t              state, state_nxt;
  logic                accept, fire, flush_en;
  logic [PIPE_LAT-1:0] v;

`ifdef PARTIAL_FLUSH_EN
  assign flush_en = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_en     = 1'b0;
`endif

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S0: if (accept) state_nxt = S1;
      S1: begin
        if (flush_en)    state_nxt = S3;
        else if (accept) state_nxt = S2;
      end
      S2: if (accept || flush_en) state_nxt = S3;
      S3: if (fire) state_nxt = accept ? S1 : S0;
      default: state_nxt = S0;
    endcase
  end

  // Ready stays up in S3 when downstream drains this cycle, giving zero-bubble reload.
  always_comb begin
    out_valid = (state == S3);
    in_ready  = (state != S3) | out_ready;
  end

  // Flush pads with the newest sample: an accepted same-cycle sample wins over the held one.
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      c <= '0;
    end else begin
      unique case (state)
        S0: if (accept) a <= in_data;
        S1: begin
          if (accept) b <= in_data;
          if (flush_en) begin
            if (accept) begin
              c <= in_data;
            end else begin
              b <= a;
              c <= a;
            end
          end
        end
        S2: begin
          if (accept)        c <= in_data;
          else if (flush_en) c <= b;
        end
        S3: if (fire && accept) a <= in_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v        <= '0;
      trip_cnt <= '0;
    end else begin
      v[0] <= fire;
      for (int unsigned i = 1; i < PIPE_LAT; i++) v[i] <= v[i-1];
      if (fire) trip_cnt <= trip_cnt + CNT_W'(1);
    end
  end

  assign avg_valid = v[PIPE_LAT-1];

endmodule

// File: tb/tb_triplet_packer.sv
// Scoreboard bench for triplet_packer: stimulus queues expected triplets/averages, a monitor pops and compares.
// Includes a 3-cycle averager model so avg_valid alignment is checked against real avg values.
module tb_triplet_packer;
  localparam int DW = 8;
  localparam int PL = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, flush, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, avg_valid;
  logic [DW-1:0] a, b, c;
  logic [CW-1:0] trip_cnt;

  int tests = 0;
  int fails = 0;
  int stalls;

  logic [3*DW-1:0] trip_q[$];
  logic [DW-1:0]   avg_q[$];
  logic [DW+1:0]   sum_w;
  logic [DW-1:0]   p1, p2, avg;

  triplet_packer #(.DATA_W(DW), .PIPE_LAT(PL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .avg_valid(avg_valid), .trip_cnt(trip_cnt)
  );

  always #5 clk = ~clk;

  // Averager reference: avg reflects a/b/c sampled three edges earlier.
  assign sum_w = {2'b00, a} + {2'b00, b} + {2'b00, c};
  always @(posedge clk) begin
    p1  <= DW'(sum_w / 3);
    p2  <= p1;
    avg <= p2;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (trip_q.size() == 0) check("unexpected_fire", {8'd0, a, b, c}, 32'hFFFF_FFFF);
        else check("triplet", {8'd0, a, b, c}, {8'd0, trip_q.pop_front()});
      end
      if (avg_valid) begin
        if (avg_q.size() == 0) check("unexpected_avg_valid", {24'd0, avg}, 32'hFFFF_FFFF);
        else check("avg", {24'd0, avg}, {24'd0, avg_q.pop_front()});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) check("send_timeout", 0, 1);
    stalls += n;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_trip(input logic [DW-1:0] x, input logic [DW-1:0] y,
                             input logic [DW-1:0] z, input logic [DW-1:0] m);
    trip_q.push_back({x, y, z});
    avg_q.push_back(m);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_data = '0;
    stalls = 0;
    cycles(3);
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_avg_valid", {31'd0, avg_valid}, 0);
    check("rst_abc", {8'd0, a, b, c}, 0);
    check("rst_trip_cnt", {28'd0, trip_cnt}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);

    // 1: single triplet
    expect_trip(30, 60, 90, 60);
    send(30); send(60); send(90);
    cycles(6);
    check("t1_trip_cnt", {28'd0, trip_cnt}, 1);
    check("t1_avg_drained", avg_q.size(), 0);

    // 2: back-to-back stream, no stalls
    stalls = 0;
    expect_trip(3, 3, 3, 3);
    expect_trip(255, 255, 255, 255);
    expect_trip(0, 1, 2, 1);
    send(3); send(3); send(3); send(255); send(255); send(255); send(0); send(1); send(2);
    check("t2_no_stall", stalls, 0);
    cycles(6);
    check("t2_trip_cnt", {28'd0, trip_cnt}, 4);

    // 3: downstream stall holds triplet and blocks input
    out_ready = 1'b0;
    expect_trip(10, 20, 30, 20);
    send(10); send(20); send(30);
    in_data = 40; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_in_ready_low", {31'd0, in_ready}, 0);
      check("t3_abc_stable", {8'd0, a, b, c}, {8'd0, 8'd10, 8'd20, 8'd30});
      cycles(1);
    end
    out_ready = 1'b1;
    #1;
    check("t3_in_ready_release", {31'd0, in_ready}, 1);
    expect_trip(40, 50, 60, 50);
    stalls = 0;
    send(40);
    check("t3_same_cycle_accept", {31'd0, out_valid, a}, {31'd0, 1'b0, 8'd40});
    send(50); send(60);
    check("t3_no_stall", stalls, 0);
    cycles(6);
    check("t3_trip_cnt", {28'd0, trip_cnt}, 6);

    // 4: reset mid-triplet discards partial samples
    send(7); send(8);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("t4_trip_cnt_cleared", {28'd0, trip_cnt}, 0);
    check("t4_abc_cleared", {8'd0, a, b, c}, 0);
    expect_trip(1, 2, 3, 2);
    send(1); send(2); send(3);
    cycles(6);
    check("t4_trip_cnt", {28'd0, trip_cnt}, 1);

    // 5: partial flush
    send(9);
    flush = 1'b1;
`ifdef PARTIAL_FLUSH_EN
    expect_trip(9, 9, 9, 9);
    cycles(1);
    flush = 1'b0;
    cycles(6);
    expect_trip(4, 5, 5, 4);
    send(4);
    flush = 1'b1; send(5); flush = 1'b0;
    expect_trip(6, 7, 7, 6);
    send(6); send(7);
    flush = 1'b1; cycles(1); flush = 1'b0;
    cycles(6);
    check("t5_trip_cnt", {28'd0, trip_cnt}, 4);
`else
    cycles(1);
    flush = 1'b0;
    cycles(5);
    check("t5_no_out_valid", {31'd0, out_valid}, 0);
    expect_trip(9, 9, 9, 9);
    send(9); send(9);
    cycles(6);
    check("t5_trip_cnt", {28'd0, trip_cnt}, 2);
`endif

    // 6: trip_cnt wrap
    do_reset();
    for (int i = 0; i < 15; i++) begin
      expect_trip(DW'(i), DW'(i), DW'(i), DW'(i));
      send(DW'(i)); send(DW'(i)); send(DW'(i));
    end
    cycles(2);
    check("t6_trip_cnt_max", {28'd0, trip_cnt}, 15);
    expect_trip(200, 100, 0, 100);
    send(200); send(100); send(0);
    cycles(2);
    check("t6_trip_cnt_wrap", {28'd0, trip_cnt}, 0);

    cycles(8);
    check("drain_trip_q", trip_q.size(), 0);
    check("drain_avg_q", avg_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
